// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared constants and entry type for the fetch buffer
package fetch_buffer_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h00003000;
    localparam logic [31:0] NOP_INSTR        = 32'h00000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// rtl/fetch_buffer_ram.sv - DEPTH x 64 register array, one write port, one combinational read port
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - fetch-to-decode decoupling queue; optional bypass via FETCH_BUF_BYPASS_EN
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       pc_en,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    fetch_entry_t wr_entry;
    fetch_entry_t rd_entry;

    logic ram_valid;
    logic bypass_act;
    logic pop;
    logic pop_ram;
    logic push;
    logic push_store;

    assign wr_entry = '{pc: in_pc, instr: in_instr};

    always_comb begin
        ram_valid = (cnt != '0);
`ifdef FETCH_BUF_BYPASS_EN
        bypass_act = (cnt == '0) && in_valid && !flush;
`else
        bypass_act = 1'b0;
`endif
        out_valid  = ram_valid || bypass_act;
        pop        = out_valid && out_ready && !flush;
        pop_ram    = pop && ram_valid;
        // Only a stored-entry pop can free a slot, keeping pc_en independent of in_valid.
        pc_en      = (cnt < FULL_CNT) || pop_ram;
        push       = in_valid && pc_en && !flush;
        push_store = push && !(bypass_act && out_ready);

        if (ram_valid) begin
            out_pc    = rd_entry.pc;
            out_instr = rd_entry.instr;
        end else if (bypass_act) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else begin
            out_pc    = RESET_PC;
            out_instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ram) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_store, pop_ram})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;

    fetch_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push_store),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Decoupling queue at the consumer end of the fetch path. Each cycle the PC register and instruction memory present an address and instruction word. The queue stores {pc, instr} pairs in order and hands them to the decode stage under a valid/ready handshake. It drives the enable that freezes the PC when it cannot accept, and it discards all contents on a branch/jump flush.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- RESET_PC, 32'h00003000, value shown on out_pc while the queue is empty

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  fetch stage presents a valid word this cycle
- in_pc  input  32  address of presented word
- in_instr  input  32  instruction word at in_pc
- pc_en  output  1  enable to PC register: 1 = PC may advance, 0 = PC frozen
- flush  input  1  branch/jump redirect; discard all queued and presented words
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode stage accepts head this cycle (0 = decode stall)
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular array of DEPTH entries, 64 bits each ({pc, instr}); write pointer, read pointer, occupancy counter.
- Push fires when in_valid && pc_en && !flush.
- Pop fires when out_valid && out_ready && !flush.
- pc_en = (count < DEPTH) || pop; a full queue still accepts a push in a cycle when it pops.
- Pointers wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- out_valid = (count != 0). out_pc and out_instr come combinationally from the entry at the read pointer.
- Empty queue: out_pc = RESET_PC, out_instr = 32'h00000000 (nop).
- Flush has priority over push and pop in the same cycle. On flush, pointers and count go to 0. The word presented that cycle is dropped and nothing is popped.
- Push and pop on an empty queue in the same cycle: without bypass, pop cannot fire (out_valid=0) and the word is stored. With bypass, see Configuration.
- Reset: count=0, pointers=0, out_valid=0, pc_en=1, out_pc=RESET_PC, out_instr=0. Storage contents are don't-care.
- Reset mid-operation discards all entries exactly as flush does. Reset takes priority over flush.

## Timing
- Push-to-out_valid latency: 1 cycle. A word pushed at edge N is visible at the head after edge N.
- pc_en is combinational from count and pop. It is valid in the same cycle and has no path from in_valid.
- A flush asserted in cycle N gives out_valid=0 and count=0 after edge N. PC redirect is external; the queue resumes accepting in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained, at any occupancy including full.
- No combinational path from out_ready to out_valid/out_pc/out_instr.

## Configuration
- FETCH_BUF_BYPASS_EN defined:
  - When count==0 and in_valid && !flush, the outputs show the presented word combinationally: out_valid=1, out_pc=in_pc, out_instr=in_instr.
  - If out_ready is also 1, the word is consumed and not stored; count stays 0.
  - This gives 0-cycle latency and adds a path from in_* to out_*.
- Not defined: no bypass; minimum latency 1 cycle as specified above.

## Structure
- A shared package holds:
  - RESET_PC default 32'h00003000
  - NOP_INSTR 32'h00000000
  - a fetch_entry_t typedef: struct {logic [31:0] pc; logic [31:0] instr;}
- One natural sub-module: fetch_buffer_ram, a DEPTH x 64 register array with one write port and one combinational read port. Pointer and count control stay in the top.

## Test plan
- Reset then idle: assert reset 2 cycles -> out_valid=0, pc_en=1, count=0, out_pc=32'h00003000, out_instr=0.
- Fill: in_valid=1 with pc 0x3000,0x3004,0x3008,0x300C, out_ready=0 -> count=4, pc_en=0 from the 5th cycle, head pc=0x3000; a 5th word held at 0x3010 is not stored.
- Full with simultaneous push+pop: count=4, out_ready=1, in_valid=1 pc 0x3010 -> pc_en=1, count stays 4, next head 0x3004, 0x3010 stored at tail; drain order 0x3004,0x3008,0x300C,0x3010.
- Wrap-around: stream 12 sequential words with out_ready toggling 1,0 -> output sequence identical to input with no loss or duplication, count never exceeds 4.
- Flush priority: count=3, same cycle flush=1, in_valid=1, out_ready=1 -> after edge count=0, out_valid=0, pc_en=1; the next push pc 0x3400 appears as head.
- Bypass (FETCH_BUF_BYPASS_EN only): empty, in_valid=1 pc 0x3000 instr 0x24010001, out_ready=1 -> same cycle out_valid=1, out_instr=0x24010001; after edge count=0.
